// File: rtl/mul_pkg.sv
// mul_pkg: shared state encoding and sizing constants for the multiply sequencer
package mul_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;
  localparam int MUL_WIDTH = 32;
  localparam int MUL_ITER  = 32;
endpackage

// File: rtl/mul_sequencer_if.sv
// mul_sequencer_if: execute-stage handshake between core control and the multiply sequencer
interface mul_sequencer_if #(parameter int WIDTH = 32);
  logic             mul;
  logic             mulUnsigned;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             busy;
  modport master (output mul, mulUnsigned, opA, opB, input stall, done, result, busy);
  modport slave  (input mul, mulUnsigned, opA, opB, output stall, done, result, busy);
endinterface

// File: rtl/mul_shift_add.sv
// mul_shift_add: magnitude shift-add datapath with sign fix-up and result register
module mul_shift_add #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             fix,
  input  logic             mul_unsigned,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result
);
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] fixed;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     sum;
  logic               neg;
  // -0x80000000 wraps to itself, which is the correct unsigned magnitude
  always_comb begin
    mag_a = (!mul_unsigned && op_a[WIDTH-1]) ? -op_a : op_a;
    mag_b = (!mul_unsigned && op_b[WIDTH-1]) ? -op_b : op_b;
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mplier[0] ? mcand : '0};
    fixed = neg ? -acc : acc;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      result <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= mag_a;
      mplier <= mag_b;
      neg    <= !mul_unsigned && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
    end else if (step) begin
      acc    <= {sum, acc[WIDTH-1:1]};
      mplier <= mplier >> 1;
    end else if (fix) begin
      acc    <= fixed;
      result <= fixed[WIDTH-1:0];
    end
  end
endmodule

// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle MULT/MULTU controller that stalls the core until the product retires
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = $clog2(MUL_ITER)
) (
  input logic            clk,
  input logic            reset,
  mul_sequencer_if.slave bus
);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  // stall in IDLE follows mul combinationally so the PC never advances past a fresh MUL
  assign bus.stall = (state == IDLE) ? bus.mul : (state != DONE);
  assign bus.done  = state == DONE;
  assign bus.busy  = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.mul) state <= CALC;
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX:     state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
  mul_shift_add #(.WIDTH(WIDTH)) dpath (
    .clk          (clk),
    .reset        (reset),
    .load         (state == IDLE && bus.mul),
    .step         (state == CALC),
    .fix          (state == FIX),
    .mul_unsigned (bus.mulUnsigned),
    .op_a         (bus.opA),
    .op_b         (bus.opB),
    .result       (bus.result)
  );
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed cycle-accurate checks of latency, sign handling, reset abort and back-to-back MULs
module tb_mul_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   fails = 0;
  mul_sequencer_if #(.WIDTH(32)) bus ();
  mul_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in an IDLE cycle (cycle 0); returns in DONE (cycle 34) with mul still high.
  task automatic run_mul(input string tag, input logic uns, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    int stall_low = 0;
    int early_done = 0;
    bus.mul = 1'b1;
    bus.mulUnsigned = uns;
    bus.opA = a;
    bus.opB = b;
    #1;
    chk({tag, " stall c0"}, 32'(bus.stall), 32'd1);
    for (int c = 1; c <= 33; c++) begin
      tick();
      if (c == 3) begin
        bus.opA = ~a;
        bus.opB = ~b;
        bus.mulUnsigned = ~uns;
      end
      if (!bus.stall) stall_low++;
      if (bus.done) early_done++;
    end
    chk({tag, " stall low during c1..33"}, 32'(stall_low), 32'd0);
    chk({tag, " done before c34"}, 32'(early_done), 32'd0);
    tick();
    chk({tag, " done c34"}, 32'(bus.done), 32'd1);
    chk({tag, " stall c34"}, 32'(bus.stall), 32'd0);
    chk({tag, " result"}, bus.result, exp);
  endtask

  initial begin
    int seen_done;
    bus.mul = 1'b0;
    bus.mulUnsigned = 1'b0;
    bus.opA = '0;
    bus.opB = '0;
    tick();
    tick();
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset stall", 32'(bus.stall), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset result", bus.result, 32'd0);
    reset = 1'b0;
    tick();
    chk("idle no mul stall", 32'(bus.stall), 32'd0);

    run_mul("multu 7x6", 1'b1, 32'd7, 32'd6, 32'h0000002A);
    bus.mul = 1'b0;
    tick();
    chk("after done busy", 32'(bus.busy), 32'd0);
    chk("after done pulse", 32'(bus.done), 32'd0);
    chk("result held", bus.result, 32'h0000002A);

    run_mul("mult -3x5", 1'b0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1);
    bus.mul = 1'b0;
    tick();
    run_mul("multu ff*ff", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    bus.mul = 1'b0;
    tick();
    run_mul("mult min*-1", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    bus.mul = 1'b0;
    tick();
    run_mul("mult -7x-9", 1'b0, 32'hFFFFFFF9, 32'hFFFFFFF7, 32'h0000003F);
    bus.mul = 1'b0;
    tick();

    // back-to-back: mul stays high through DONE; cycle 35 must be IDLE, not a restart
    run_mul("b2b 3x4", 1'b0, 32'd3, 32'd4, 32'h0000000C);
    tick();
    chk("b2b c35 busy", 32'(bus.busy), 32'd0);
    chk("b2b c35 stall", 32'(bus.stall), 32'd1);
    run_mul("b2b 5x5", 1'b0, 32'd5, 32'd5, 32'h00000019);
    bus.mul = 1'b0;
    tick();

    // reset abort mid-CALC
    bus.mul = 1'b1;
    bus.mulUnsigned = 1'b0;
    bus.opA = 32'd12;
    bus.opB = 32'd12;
    for (int c = 1; c <= 10; c++) tick();
    chk("abort busy c10", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    bus.mul = 1'b0;
    tick();
    chk("abort busy c11", 32'(bus.busy), 32'd0);
    chk("abort stall c11", 32'(bus.stall), 32'd0);
    chk("abort result c11", bus.result, 32'd0);
    chk("abort done c11", 32'(bus.done), 32'd0);
    reset = 1'b0;
    seen_done = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.done) seen_done++;
    end
    chk("abort no done", 32'(seen_done), 32'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
